// File: rtl/load_store_unit.sv
// Load/store unit: runs one data-memory transaction per load or store instruction.
// The transaction uses a request/grant/response bus. The unit stalls the core while
// the access is in flight, and it flags misaligned or illegal accesses without
// touching memory.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   req_valid/req_write  access request and direction (1 = store)
//   req_funct3           RV32I funct3 giving size and signedness
//   alu_result           effective address
//   store_data           rs2 value, unshifted
//   stall                hold PC and register-file write
//   lsu_done             one-cycle completion pulse
//   load_data            extended load result
//   misaligned_fault     misaligned access or illegal funct3
//   mem_*                request/grant/response memory bus
module load_store_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  input  logic            req_write,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] store_data,
  output logic            stall,
  output logic            lsu_done,
  output logic [XLEN-1:0] load_data,
  output logic            misaligned_fault,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_be,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  state_e          state_q;
  logic            mem_req_q, mem_we_q, lsu_done_q;
  logic [XLEN-1:0] mem_addr_q, mem_wdata_q, load_data_q;
  logic [3:0]      mem_be_q;
  logic [2:0]      funct3_q;
  logic [1:0]      off_q;

  logic            legal;
  logic [1:0]      off;
  logic [XLEN-1:0] wdata_d, load_data_d, rdata_sh;
  logic [3:0]      be_d;
  logic [7:0]      rbyte;
  logic [15:0]     rhalf;

  assign off = alu_result[1:0];

  // Legality check covers both the funct3 encoding and the natural alignment.
  always_comb begin
    legal = 1'b0;
    unique case (req_funct3)
      3'd0:       legal = 1'b1;
      3'd1:       legal = ~off[0];
      3'd2:       legal = (off == 2'b00);
      3'd4:       legal = ~req_write;
      3'd5:       legal = ~req_write & ~off[0];
      default:    legal = 1'b0;
    endcase
  end

  // Store lane placement; loads reuse the same byte-enable pattern.
  always_comb begin
    be_d    = 4'hF;
    wdata_d = store_data;
    unique case (req_funct3[1:0])
      2'd0: begin
        be_d    = 4'b0001 << off;
        wdata_d = {4{store_data[7:0]}};
      end
      2'd1: begin
        be_d    = off[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{store_data[15:0]}};
      end
      default: begin
        be_d    = 4'hF;
        wdata_d = store_data;
      end
    endcase
  end

  // Load extraction uses the latched offset and funct3 because the request inputs
  // belong to the retiring instruction and are not guaranteed stable.
  assign rdata_sh = mem_rdata >> {off_q, 3'b000};
  assign rbyte    = rdata_sh[7:0];
  assign rhalf    = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    load_data_d = mem_rdata;
    unique case (funct3_q)
      3'd0:    load_data_d = {{(XLEN-8){rbyte[7]}}, rbyte};
      3'd1:    load_data_d = {{(XLEN-16){rhalf[15]}}, rhalf};
      3'd4:    load_data_d = {{(XLEN-8){1'b0}}, rbyte};
      3'd5:    load_data_d = {{(XLEN-16){1'b0}}, rhalf};
      default: load_data_d = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= 4'h0;
      funct3_q    <= 3'd0;
      off_q       <= 2'd0;
      lsu_done_q  <= 1'b0;
      load_data_q <= '0;
    end else begin
      lsu_done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_valid && legal) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= req_write;
            mem_addr_q  <= {alu_result[XLEN-1:2], 2'b00};
            mem_wdata_q <= wdata_d;
            mem_be_q    <= be_d;
            funct3_q    <= req_funct3;
            off_q       <= off;
            state_q     <= StReq;
          end
        end
        StReq: begin
          if (mem_gnt) begin
            mem_req_q <= 1'b0;
            state_q   <= StWait;
          end
        end
        StWait: begin
          if (mem_rvalid) begin
            if (!mem_we_q) load_data_q <= load_data_d;
            lsu_done_q <= 1'b1;
            state_q    <= StDone;
          end
        end
        // req_valid is still high for the retiring instruction here; never relaunch.
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign misaligned_fault = (state_q == StIdle) & req_valid & ~legal;
  assign stall = ((state_q == StIdle) & req_valid & legal) |
                 (state_q == StReq) | (state_q == StWait);

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign lsu_done  = lsu_done_q;
  assign load_data = load_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_write;
  logic [2:0]  req_funct3;
  logic [31:0] alu_result, store_data;
  logic        stall, lsu_done, misaligned_fault;
  logic [31:0] load_data;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  load_store_unit #(.XLEN(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_write        (req_write),
    .req_funct3       (req_funct3),
    .alu_result       (alu_result),
    .store_data       (store_data),
    .stall            (stall),
    .lsu_done         (lsu_done),
    .load_data        (load_data),
    .misaligned_fault (misaligned_fault),
    .mem_req          (mem_req),
    .mem_we           (mem_we),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .mem_be           (mem_be),
    .mem_gnt          (mem_gnt),
    .mem_rvalid       (mem_rvalid),
    .mem_rdata        (mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Move to just after the next rising edge; inputs are driven from here.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Full legal access with gnt_wait REQ cycles lacking grant and rv_wait WAIT
  // cycles lacking rvalid. Counts stall cycles and done pulses across the access.
  task automatic access(input string name, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] sdata,
                        input logic [31:0] rdata, input int gnt_wait, input int rv_wait,
                        input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                        input logic [31:0] exp_ld, input int exp_stall);
    int stalls;
    int dones;
    stalls = 0;
    dones  = 0;
    req_valid  = 1'b1;
    req_write  = wr;
    req_funct3 = f3;
    alu_result = addr;
    store_data = sdata;
    #1;
    chk({name, "_idle_stall"}, 32'(stall), 32'd1);
    chk({name, "_idle_fault"}, 32'(misaligned_fault), 32'd0);
    if (stall) stalls++;
    next_cycle();
    for (int i = 0; i <= gnt_wait; i++) begin
      mem_gnt = (i == gnt_wait);
      #1;
      chk({name, "_req"}, 32'(mem_req), 32'd1);
      chk({name, "_addr"}, mem_addr, {addr[31:2], 2'b00});
      chk({name, "_be"}, 32'(mem_be), 32'(exp_be));
      chk({name, "_wdata"}, mem_wdata, exp_wdata);
      chk({name, "_we"}, 32'(mem_we), 32'(wr));
      if (stall) stalls++;
      if (lsu_done) dones++;
      next_cycle();
      mem_gnt = 1'b0;
    end
    for (int i = 0; i <= rv_wait; i++) begin
      mem_rvalid = (i == rv_wait);
      mem_rdata  = rdata;
      #1;
      chk({name, "_wait_req"}, 32'(mem_req), 32'd0);
      if (stall) stalls++;
      if (lsu_done) dones++;
      next_cycle();
      mem_rvalid = 1'b0;
      mem_rdata  = 32'h0;
    end
    #1;
    chk({name, "_done"}, 32'(lsu_done), 32'd1);
    chk({name, "_done_stall"}, 32'(stall), 32'd0);
    if (!wr) chk({name, "_load"}, load_data, exp_ld);
    if (stall) stalls++;
    if (lsu_done) dones++;
    next_cycle();
    req_valid = 1'b0;
    #1;
    chk({name, "_post_req"}, 32'(mem_req), 32'd0);
    if (!wr) chk({name, "_load_hold"}, load_data, exp_ld);
    if (lsu_done) dones++;
    chk({name, "_stalls"}, 32'(stalls), 32'(exp_stall));
    chk({name, "_dones"}, 32'(dones), 32'd1);
    next_cycle();
  endtask

  task automatic fault(input string name, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr);
    req_valid  = 1'b1;
    req_write  = wr;
    req_funct3 = f3;
    alu_result = addr;
    #1;
    chk({name, "_fault"}, 32'(misaligned_fault), 32'd1);
    chk({name, "_stall"}, 32'(stall), 32'd0);
    chk({name, "_req"}, 32'(mem_req), 32'd0);
    next_cycle();
    req_valid = 1'b0;
    #1;
    chk({name, "_fault_off"}, 32'(misaligned_fault), 32'd0);
    chk({name, "_req_after"}, 32'(mem_req), 32'd0);
    next_cycle();
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_funct3 = 3'd0;
    alu_result = 32'h0;
    store_data = 32'h0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    next_cycle();
    next_cycle();
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_done", 32'(lsu_done), 32'd0);
    chk("rst_load", load_data, 32'h0);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_be", 32'(mem_be), 32'h0);
    rst = 1'b0;
    next_cycle();

    access("lw", 1'b0, 3'd2, 32'h1004, 32'h0, 32'hDEADBEEF, 0, 0,
           4'hF, 32'h0, 32'hDEADBEEF, 3);
    access("lb", 1'b0, 3'd0, 32'h2003, 32'h0, 32'h80F17F02, 0, 0,
           4'b1000, 32'h0, 32'hFFFFFF80, 3);
    access("lbu", 1'b0, 3'd4, 32'h2003, 32'h0, 32'h80F17F02, 0, 0,
           4'b1000, 32'h0, 32'h00000080, 3);
    access("lh", 1'b0, 3'd1, 32'h2002, 32'h0, 32'h80F17F02, 0, 0,
           4'b1100, 32'h0, 32'hFFFF80F1, 3);
    access("lhu", 1'b0, 3'd5, 32'h2000, 32'h0, 32'h80F17F02, 0, 0,
           4'b0011, 32'h0, 32'h00007F02, 3);
    access("sb", 1'b1, 3'd0, 32'h3001, 32'h12345678, 32'h0, 0, 0,
           4'b0010, 32'h78787878, 32'h0, 3);
    access("sh", 1'b1, 3'd1, 32'h3002, 32'h12345678, 32'h0, 0, 0,
           4'b1100, 32'h56785678, 32'h0, 3);
    access("sw", 1'b1, 3'd2, 32'h3000, 32'h12345678, 32'h0, 0, 0,
           4'hF, 32'h12345678, 32'h0, 3);

    fault("flw", 1'b0, 3'd2, 32'h4002);
    fault("fsh", 1'b1, 3'd1, 32'h4001);
    fault("ff3", 1'b0, 3'd3, 32'h4000);

    access("slow", 1'b1, 3'd2, 32'h5008, 32'hCAFEF00D, 32'h0, 3, 1,
           4'hF, 32'hCAFEF00D, 32'h0, 7);

    // Stray rvalid while idle must be ignored.
    mem_rvalid = 1'b1;
    next_cycle();
    mem_rvalid = 1'b0;
    #1;
    chk("idle_rvalid_done", 32'(lsu_done), 32'd0);
    next_cycle();

    // Reset while in WAIT abandons the access.
    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_funct3 = 3'd2;
    alu_result = 32'h6000;
    next_cycle();
    mem_gnt = 1'b1;
    next_cycle();
    mem_gnt = 1'b0;
    req_valid = 1'b0;
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    #1;
    chk("rstw_req", 32'(mem_req), 32'd0);
    chk("rstw_stall", 32'(stall), 32'd0);
    chk("rstw_load", load_data, 32'h0);
    chk("rstw_addr", mem_addr, 32'h0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h11111111;
    next_cycle();
    mem_rvalid = 1'b0;
    #1;
    chk("rstw_done0", 32'(lsu_done), 32'd0);
    next_cycle();
    chk("rstw_done1", 32'(lsu_done), 32'd0);
    chk("rstw_load2", load_data, 32'h0);
    chk("rstw_req2", 32'(mem_req), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
